alu_sequencer: RTL
==================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, ALU datapath width; only 8 is supported.
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clk, input, 1, rising-edge clock; reset_n, input, 1, asynchronous active-low reset.
REQ-003 cmd_valid  input  1  command offered.
REQ-004 cmd_ready  output  1  sequencer can accept a command.
REQ-005 cmd_src1 / cmd_src2  input  3  ALU operand mux codes: 1 A, 2 X, 3 Y, 4 DATA, 5 SP, 6 ONE.
REQ-006 cmd_op  input  8  ALU opcode: 01 AND, 02 OR, 03 XOR, 04 NOT, 11 ASL, 12 ROL, 13 ASR, 14 ROR, 21 ADD, 22 INC, 23 SUB, 24 DEC (hex).
REQ-007 cmd_dest  input  3  writeback target: 0 none, 1 A, 2 X, 3 Y, 4 DATA, 5 SP.
REQ-008 cmd_cin_mode  input  2  carry-in source: 0 zero, 1 one, 2 flag_c.
REQ-009 cmd_set_flags  input  1  update N/Z/C from this operation.
REQ-010 input_1_select / input_2_select  output  3  ALU operand selects.
REQ-011 alu_opcode  output  8  ALU opcode.
REQ-012 alu_cin  output  1  ALU carry-in.
REQ-013 alu_out  input  8  combinational ALU result.
REQ-014 alu_cout  input  1  combinational ALU carry-out.
REQ-015 wb_en  output  1  writeback strobe.
REQ-016 wb_dest  output  3  writeback target.
REQ-017 wb_data  output  8  writeback value.
REQ-018 flag_n / flag_z / flag_c  output  1 each  status flags.
REQ-019 done  output  1  one-cycle completion pulse.

Function
REQ-020 SHALL implement the FSM IDLE -> EXEC -> WB -> IDLE, with exactly one cycle per state.
REQ-021 IDLE: cmd_ready=1; all ALU-side outputs 0 (opcode 00 = no-op); on cmd_valid=1 at a rising edge, latch every cmd_* field and go to EXEC.
REQ-022 cmd_ready SHALL be 0 in EXEC and WB; cmd_valid there is ignored and the command is not consumed.
REQ-023 EXEC: drive the selects and opcode from the latched fields; drive alu_cin per cin_mode, using the flag_c value held before this command; at the closing edge, register alu_out into result and alu_cout into carry, then go to WB.
REQ-024 WB: done=1; wb_dest=latched dest; wb_data=result; wb_en=1 only if dest is 1..5; at the closing edge go to IDLE.
REQ-025 Flag update SHALL occur at the WB closing edge when set_flags=1: N=result[7], Z=(result==0), C=carry; when set_flags=0, flags hold.
REQ-026 Latency: command accepted at edge k -> wb_en/done high during cycle k+2 -> cmd_ready high again at cycle k+3; throughput is one command per 3 cycles.
REQ-027 dest 6 or 7 SHALL act as none (wb_en=0), while done still pulses.
REQ-028 cin_mode 3 SHALL act as 0.
REQ-029 Select codes 0 or 7 and unlisted opcodes SHALL pass through unchanged; the sequencer does not validate them.
REQ-030 wb_dest and wb_data SHALL be 0 outside WB.
REQ-031 The flags SHALL be readable in every state and are not cleared by commands with set_flags=0.

Reset
REQ-032 reset_n=0 SHALL asynchronously force state IDLE; all outputs 0 except cmd_ready=1; flags 0; latched fields 0.
REQ-033 Reset during EXEC or WB SHALL abort the command: no wb_en, no done, no flag change after release.
REQ-034 The first command SHALL be accepted no earlier than the first rising edge after reset_n goes 1.

Verification
REQ-035 ADD A+X, dest A, cin 0, set_flags=1, ALU returning 03, cout 0 -> two cycles after accept: wb_en=1, wb_dest=1, wb_data=03, done=1; afterwards N=0, Z=0, C=0.
REQ-036 SUB ONE-ONE, dest none, cin 1, set_flags=1, ALU returning 00, cout 1 -> wb_en=0, done=1, Z=1, C=1, N=0.
REQ-037 With flag_c=1, a cin_mode=2 command -> alu_cin=1 throughout EXEC; with flag_c=0 -> alu_cin=0.
REQ-038 cmd_valid held high for 9 cycles with 3 distinct commands -> exactly 3 accepts, 3 done pulses spaced 3 cycles apart, results in order.
REQ-039 reset_n pulsed low during EXEC -> no wb_en/done, flags 00 0, cmd_ready=1 immediately.
REQ-040 set_flags=0, ALU returning 80 -> flags unchanged from the prior values, wb_data=80.

Source files
------------

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//   Three-state command sequencer in front of an external combinational ALU.
//   A command is accepted in IDLE. EXEC drives the ALU with the latched
//   operand selects, opcode and carry-in, then captures the ALU result.
//   WB presents the captured result and pulses done.
//
// Ports
//   clk, reset_n                      clock, async active-low reset
//   cmd_valid / cmd_ready             command handshake
//   cmd_src1, cmd_src2, cmd_op,
//   cmd_dest, cmd_cin_mode,
//   cmd_set_flags                     command fields
//   input_1_select, input_2_select,
//   alu_opcode, alu_cin               ALU control (non-zero in EXEC only)
//   alu_out, alu_cout                 combinational ALU result
//   wb_en, wb_dest, wb_data           writeback (non-zero in WB only)
//   flag_n, flag_z, flag_c            status flags
//   done                              one-cycle completion pulse
//
// State table
//   state | meaning
//   IDLE  | ready for a command, ALU side held at no-op
//   EXEC  | ALU driven from latched command, result captured at exit
//   WB    | writeback and done presented, flags updated at exit
// ---------------------------------------------------------------------------
module alu_sequencer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_src1,
  input  logic [2:0]        cmd_src2,
  input  logic [7:0]        cmd_op,
  input  logic [2:0]        cmd_dest,
  input  logic [1:0]        cmd_cin_mode,
  input  logic              cmd_set_flags,
  output logic [2:0]        input_1_select,
  output logic [2:0]        input_2_select,
  output logic [7:0]        alu_opcode,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_cout,
  output logic              wb_en,
  output logic [2:0]        wb_dest,
  output logic [DATA_W-1:0] wb_data,
  output logic              flag_n,
  output logic              flag_z,
  output logic              flag_c,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [2:0]        lat_src1;
  logic [2:0]        lat_src2;
  logic [7:0]        lat_op;
  logic [2:0]        lat_dest;
  logic [1:0]        lat_cin_mode;
  logic              lat_set_flags;
  logic [DATA_W-1:0] result;
  logic              carry;

  logic accept;
  assign accept = (state == ST_IDLE) && cmd_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_src1      <= '0;
      lat_src2      <= '0;
      lat_op        <= '0;
      lat_dest      <= '0;
      lat_cin_mode  <= '0;
      lat_set_flags <= 1'b0;
    end else if (accept) begin
      lat_src1      <= cmd_src1;
      lat_src2      <= cmd_src2;
      lat_op        <= cmd_op;
      lat_dest      <= cmd_dest;
      lat_cin_mode  <= cmd_cin_mode;
      lat_set_flags <= cmd_set_flags;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result <= '0;
      carry  <= 1'b0;
    end else if (state == ST_EXEC) begin
      result <= alu_out;
      carry  <= alu_cout;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else if (state == ST_WB && lat_set_flags) begin
      flag_n <= result[DATA_W-1];
      flag_z <= (result == '0);
      flag_c <= carry;
    end
  end

  // flag_c here is still the pre-command value: flags only move at WB exit.
  logic cin_sel;
  always_comb begin
    cin_sel = 1'b0;
    case (lat_cin_mode)
      2'd1:    cin_sel = 1'b1;
      2'd2:    cin_sel = flag_c;
      default: cin_sel = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt      = state;
    cmd_ready      = 1'b0;
    input_1_select = '0;
    input_2_select = '0;
    alu_opcode     = '0;
    alu_cin        = 1'b0;
    wb_en          = 1'b0;
    wb_dest        = '0;
    wb_data        = '0;
    done           = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        input_1_select = lat_src1;
        input_2_select = lat_src2;
        alu_opcode     = lat_op;
        alu_cin        = cin_sel;
        state_nxt      = ST_WB;
      end
      ST_WB: begin
        done      = 1'b1;
        wb_dest   = lat_dest;
        wb_data   = result;
        // Codes 6 and 7 are treated like 0: no writeback target.
        wb_en     = (lat_dest >= 3'd1) && (lat_dest <= 3'd5);
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
